// File: rtl/dsp_systolic_pkg.sv
// Shared types, limits and latency/width helpers for the 27x27 systolic dot-product chain
// and its operand feeder.
package dsp_systolic_pkg;

    localparam int PIPELINE_MIN = 2;
    localparam int PIPELINE_MAX = 4;

    localparam int AX_WIDTH_DEF = 27;
    localparam int AY_WIDTH_DEF = 27;

    typedef logic [AX_WIDTH_DEF-1:0] ax_lane_t;
    typedef logic [AY_WIDTH_DEF-1:0] ay_lane_t;

    // Edges from the feeder lane-0 output to a valid chain result.
    function automatic int dot_latency(input int num, input int pipeline);
        return num + pipeline - 1;
    endfunction

    // Bits needed to hold the sum of num full-scale unsigned products.
    function automatic int dot_width(input int axw, input int ayw, input int num);
        return axw + ayw + $clog2(num);
    endfunction

endpackage

// File: rtl/dsp_skew_line.sv
// Plain resettable shift register used to delay operand lanes and the valid strobe;
// DEPTH=0 degenerates to a wire.
module dsp_skew_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst};
            assign q_o = d_i;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] stage_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q[0] <= d_i;
                    for (int k = 1; k < DEPTH; k++) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_systolic_skew_feeder.sv
// Operand feeder for the chained 27x27 dot product: skews lane i by i cycles, emits an
// aligned result-valid strobe and throttles input with result-buffer credits.
// Build option: DSP_SKEW_ZERO_BUBBLE_EN makes idle cycles feed zeros into the chain.
module dsp_systolic_skew_feeder
    import dsp_systolic_pkg::*;
#(
    parameter int NUM            = 4,
    parameter int AX_WIDTH       = 27,
    parameter int AY_WIDTH       = 27,
    parameter int PIPELINE       = 3,
    parameter int DOT_LATENCY    = dot_latency(NUM, PIPELINE),
    parameter int RES_DEPTH      = 16,
    parameter int RESULT_A_WIDTH = dot_width(AX_WIDTH, AY_WIDTH, NUM),
    localparam int CW            = $clog2(RES_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM-1:0][AX_WIDTH-1:0]  in_ax,
    input  logic [NUM-1:0][AY_WIDTH-1:0]  in_ay,
    output logic [NUM-1:0][AX_WIDTH-1:0]  ax,
    output logic [NUM-1:0][AY_WIDTH-1:0]  ay,
    output logic                          res_valid,
    input  logic                          credit_return,
    output logic [CW-1:0]                 credits,
    output logic                          err_credit
);

    generate
        if (PIPELINE < PIPELINE_MIN || PIPELINE > PIPELINE_MAX) begin : g_bad_pipeline
            $fatal(1, "dsp_systolic_skew_feeder: PIPELINE out of range");
        end
        if (RESULT_A_WIDTH < dot_width(AX_WIDTH, AY_WIDTH, NUM)) begin : g_bad_width
            $fatal(1, "dsp_systolic_skew_feeder: chain result too narrow for dot product");
        end
        if (RES_DEPTH < 1) begin : g_bad_depth
            $fatal(1, "dsp_systolic_skew_feeder: RES_DEPTH must be at least 1");
        end
    endgenerate

    logic                         accept;
    logic [NUM-1:0][AX_WIDTH-1:0] lane0_ax_q, lane0_ax_d;
    logic [NUM-1:0][AY_WIDTH-1:0] lane0_ay_q, lane0_ay_d;
    logic                         valid_q;
    logic [CW-1:0]                credits_q, credits_d;
    logic                         err_q, err_d;
    logic                         credit_full;
    logic                         return_ok;

    assign in_ready = ~rst & (credits_q != '0);
    assign accept   = in_valid & in_ready;

    always_comb begin
`ifdef DSP_SKEW_ZERO_BUBBLE_EN
        lane0_ax_d = '0;
        lane0_ay_d = '0;
`else
        lane0_ax_d = lane0_ax_q;
        lane0_ay_d = lane0_ay_q;
`endif
        if (accept) begin
            lane0_ax_d = in_ax;
            lane0_ay_d = in_ay;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane0_ax_q <= '0;
            lane0_ay_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            lane0_ax_q <= lane0_ax_d;
            lane0_ay_q <= lane0_ay_d;
            valid_q    <= accept;
        end
    end

    // Lane gi gets gi extra stages so its product meets the chain adder on time.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
            dsp_skew_line #(
                .WIDTH (AX_WIDTH),
                .DEPTH (gi)
            ) u_ax_line (
                .clk (clk),
                .rst (rst),
                .d_i (lane0_ax_q[gi]),
                .q_o (ax[gi])
            );

            dsp_skew_line #(
                .WIDTH (AY_WIDTH),
                .DEPTH (gi)
            ) u_ay_line (
                .clk (clk),
                .rst (rst),
                .d_i (lane0_ay_q[gi]),
                .q_o (ay[gi])
            );
        end
    endgenerate

    dsp_skew_line #(
        .WIDTH (1),
        .DEPTH (DOT_LATENCY)
    ) u_valid_line (
        .clk (clk),
        .rst (rst),
        .d_i (valid_q),
        .q_o (res_valid)
    );

    // A return while already full has no slot to free; it is dropped and flagged.
    assign credit_full = (credits_q == CW'(RES_DEPTH));
    assign return_ok   = credit_return & ~credit_full;

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q | (credit_return & credit_full);
        if (accept && !return_ok) begin
            credits_d = credits_q - CW'(1);
        end else if (return_ok && !accept) begin
            credits_d = credits_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CW'(RES_DEPTH);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credits    = credits_q;
    assign err_credit = err_q;

endmodule
